// File: rtl/wbc_rr_arbiter.sv
// Round-robin WISHBONE control-intercon arbiter with a stalled-strobe watchdog.
// Grants are held for a whole cyc tenure; stalled strobes are aborted with a one-cycle error pulse.
module wbc_rr_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int TIMEOUT     = 255,
    parameter int TO_WIDTH    = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] req_i,
    input  logic       stb_i,
    input  logic       slv_ack_i,
    input  logic       slv_err_i,
    input  logic       slv_rty_i,
    output logic [3:0] gnt_o,
    output logic [1:0] gnt_idx_o,
    output logic       busy_o,
    output logic       to_err_o,
    output logic [7:0] to_count_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } state_t;

    localparam logic [1:0]          LAST_INIT = 2'(NUM_MASTERS - 1);
    localparam logic [TO_WIDTH-1:0] WD_LAST   = TO_WIDTH'(TIMEOUT - 1);
    localparam logic [TO_WIDTH-1:0] WD_ONE    = TO_WIDTH'(1);

    state_t              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic [1:0]          last_q, last_d;
    logic [3:0]          gnt_q, gnt_d;
    logic [TO_WIDTH-1:0] wd_q, wd_d;
    logic                abort_new_q, abort_new_d;
    logic                to_err_q, to_err_d;
    logic [7:0]          to_count_q, to_count_d;

    logic [1:0]          cand;
    logic [1:0]          pick_idx;
    logic                pick_found;
    logic                owner_req;
    logic                slv_term;

    assign owner_req = req_i[owner_q];
    assign slv_term  = slv_ack_i | slv_err_i | slv_rty_i;

    // Search starts just after the last owner, so only indices below NUM_MASTERS are ever examined.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_q;
        cand       = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = 2'((int'(last_q) + i) % NUM_MASTERS);
            if (!pick_found && req_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        wd_d        = wd_q;
        abort_new_d = 1'b0;
        to_err_d    = abort_new_q;
        to_count_d  = to_count_q;
        gnt_d       = '0;

        unique case (state_q)
            IDLE: begin
                wd_d = '0;
                if (pick_found) begin
                    state_d = OWN;
                    owner_d = pick_idx;
                end
            end
            OWN: begin
                // A dropped request outranks a timeout firing in the same cycle.
                if (!owner_req) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    wd_d    = '0;
                end else if (!stb_i || slv_term) begin
                    wd_d = '0;
                end else if (wd_q == WD_LAST) begin
                    state_d     = ABORT;
                    wd_d        = '0;
                    abort_new_d = 1'b1;
                    if (to_count_q != 8'hFF) begin
                        to_count_d = to_count_q + 8'd1;
                    end
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
            end
            ABORT: begin
                wd_d = '0;
                if (!owner_req) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
                wd_d    = '0;
            end
        endcase

        if (state_d != IDLE) begin
            gnt_d = 4'b0001 << owner_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_q      <= LAST_INIT;
            gnt_q       <= '0;
            wd_q        <= '0;
            abort_new_q <= 1'b0;
            to_err_q    <= 1'b0;
            to_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            wd_q        <= wd_d;
            abort_new_q <= abort_new_d;
            to_err_q    <= to_err_d;
            to_count_q  <= to_count_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign gnt_idx_o  = owner_q;
    assign busy_o     = (state_q != IDLE);
    assign to_err_o   = to_err_q;
    assign to_count_o = to_count_q;

endmodule

// File: tb/tb_wbc_rr_arbiter.sv
// Scoreboard bench for wbc_rr_arbiter: expected grants and error pulses are queued by the
// stimulus process and consumed by a negedge monitor whenever the DUT presents one.
module tb_wbc_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       stb = 1'b0;
    logic       ack = 1'b0;
    logic       err = 1'b0;
    logic       rty = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       to_err;
    logic [7:0] to_count;

    wbc_rr_arbiter #(
        .NUM_MASTERS(3),
        .TIMEOUT    (4),
        .TO_WIDTH   (8)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .req_i     (req),
        .stb_i     (stb),
        .slv_ack_i (ack),
        .slv_err_i (err),
        .slv_rty_i (rty),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .busy_o    (busy),
        .to_err_o  (to_err),
        .to_count_o(to_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int cyc;
    } gnt_exp_t;

    gnt_exp_t gnt_exp_q[$];
    int       err_exp_q[$];
    int       n_checks = 0;
    int       n_errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: a rising busy_o is a new grant, any to_err_o high cycle is an abort pulse.
    logic     prev_busy = 1'b0;
    gnt_exp_t mon_g;
    int       mon_c;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                if (gnt_exp_q.size() == 0) begin
                    checkOutput("unexpected_grant", 32'(gnt), 32'd0);
                end else begin
                    mon_g = gnt_exp_q.pop_front();
                    checkOutput("grant_onehot", 32'(gnt), 32'(1 << mon_g.idx));
                    checkOutput("grant_idx", 32'(gnt_idx), 32'(mon_g.idx));
                    checkOutput("grant_cycle", 32'(cyc), 32'(mon_g.cyc));
                end
            end
            if (to_err) begin
                if (err_exp_q.size() == 0) begin
                    checkOutput("unexpected_to_err", 32'(to_err), 32'd0);
                end else begin
                    mon_c = err_exp_q.pop_front();
                    checkOutput("to_err_cycle", 32'(cyc), 32'(mon_c));
                end
            end
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called while the arbiter is idle with idx winning at the next edge; holds the grant,
    // releases it, checks the idle gap, and optionally re-requests.
    task automatic applyStimulus(input int idx, input int hold, input bit rereq);
        gnt_exp_q.push_back('{idx: idx, cyc: cyc + 1});
        repeat (hold) tick();
        checkOutput("grant_held", 32'(gnt), 32'(1 << idx));
        req[idx] = 1'b0;
        tick();
        checkOutput("idle_gap_gnt", 32'(gnt), 32'd0);
        checkOutput("idle_gap_busy", 32'(busy), 32'd0);
        if (rereq) req[idx] = 1'b1;
    endtask

    initial begin
        #1;
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_idx", 32'(gnt_idx), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_to_err", 32'(to_err), 32'd0);
        checkOutput("reset_count", 32'(to_count), 32'd0);
        tick();
        tick();

        // Release with three requests: rotation 0,1,2,0,1,2 with one idle cycle between grants.
        req   = 4'b0111;
        rst_n = 1'b1;
        for (int g = 0; g < 6; g++) applyStimulus(g % 3, 3, 1'b1);
        applyStimulus(0, 2, 1'b1);

        // Owner 1 stalls: error pulse five cycles after strobe rose, grant held until req drops.
        gnt_exp_q.push_back('{idx: 1, cyc: cyc + 1});
        tick();
        stb = 1'b1;
        err_exp_q.push_back(cyc + 5);
        repeat (6) tick();
        checkOutput("abort_count", 32'(to_count), 32'd1);
        checkOutput("abort_gnt_held", 32'(gnt), 32'b0010);
        stb = 1'b0;
        tick();
        tick();
        checkOutput("abort_gnt_still", 32'(gnt), 32'b0010);
        checkOutput("abort_busy", 32'(busy), 32'd1);
        req[1] = 1'b0;
        tick();
        checkOutput("abort_release", 32'(gnt), 32'd0);
        req[1] = 1'b1;

        // Owner 2: ack on the last counter value clears the watchdog, no abort follows.
        gnt_exp_q.push_back('{idx: 2, cyc: cyc + 1});
        tick();
        stb = 1'b1;
        repeat (3) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (3) tick();
        stb = 1'b0;
        repeat (3) tick();
        checkOutput("ack_wins_gnt", 32'(gnt), 32'b0100);
        checkOutput("ack_wins_count", 32'(to_count), 32'd1);

        // Asynchronous reset mid-tenure drops the grant without waiting for an edge.
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_gnt", 32'(gnt), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_count", 32'(to_count), 32'd0);
        tick();
        rst_n = 1'b1;

        // Master 0 wins after reset; its request drops in the cycle the timeout would fire.
        gnt_exp_q.push_back('{idx: 0, cyc: cyc + 1});
        tick();
        stb = 1'b1;
        repeat (3) tick();
        req = 4'b0000;
        tick();
        checkOutput("drop_wins_gnt", 32'(gnt), 32'd0);
        checkOutput("drop_wins_busy", 32'(busy), 32'd0);
        checkOutput("drop_wins_count", 32'(to_count), 32'd0);
        stb = 1'b0;
        req = 4'b0001;

        // Repeated forced timeouts by master 0 alone: the abort count saturates at 8'hFF.
        for (int i = 0; i < 300; i++) begin
            gnt_exp_q.push_back('{idx: 0, cyc: cyc + 1});
            tick();
            stb = 1'b1;
            err_exp_q.push_back(cyc + 5);
            repeat (5) tick();
            stb = 1'b0;
            req[0] = 1'b0;
            tick();
            checkOutput("sat_count", 32'(to_count), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
            req[0] = 1'b1;
        end
        req = 4'b0000;
        repeat (3) tick();

        checkOutput("grant_queue_drained", 32'(gnt_exp_q.size()), 32'd0);
        checkOutput("err_queue_drained", 32'(err_exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
